// File: rtl/bmc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bmc_seq_ctrl
//
// Sequencer for a time-shared Viterbi BMC/ACS bank. Each accepted received
// pair is held in rx_pair while the bank walks over NUM_GROUPS state groups,
// one group per cycle. After every TB_LEN completed trellis steps a traceback
// is launched. The block then waits for the traceback unit before it accepts
// more input.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   in_valid   : a received pair is offered on rx_pair_in
//   rx_pair_in : offered received pair
//   in_ready   : pair is accepted this cycle if in_valid is also high
//   rx_pair    : registered pair broadcast to the BMC instances
//   grp_idx    : state group currently enabled in the bank
//   acs_en     : bank computes/updates metrics for grp_idx this cycle
//   step_done  : one-cycle pulse on the final group of a step
//   pm_sel     : ping-pong path-metric bank select, toggles per step
//   tb_start   : one-cycle traceback launch pulse
//   tb_done    : traceback unit finished
//   busy       : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module bmc_seq_ctrl #(
  parameter int NUM_GROUPS = 8,
  parameter int TB_LEN     = 32,
  parameter int GW         = $clog2(NUM_GROUPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [1:0]    rx_pair_in,
  output logic          in_ready,
  output logic [1:0]    rx_pair,
  output logic [GW-1:0] grp_idx,
  output logic          acs_en,
  output logic          step_done,
  output logic          pm_sel,
  output logic          tb_start,
  input  logic          tb_done,
  output logic          busy
);

  localparam int            SW        = $clog2(TB_LEN);
  localparam logic [GW-1:0] LAST_GRP  = GW'(NUM_GROUPS - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(TB_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    TB_WAIT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] grp_idx_nxt;
  logic [SW-1:0] step_cnt, step_cnt_nxt;
  logic          pm_sel_nxt;
  logic [1:0]    rx_pair_nxt;
  // Marks the first TB_WAIT cycle so tb_start is a clean registered pulse.
  logic          tb_first, tb_first_nxt;

  logic          last_grp;
  logic          last_step;
  logic          accept;

  assign last_grp  = (grp_idx == LAST_GRP);
  assign last_step = (step_cnt == LAST_STEP);
  assign accept    = in_valid && in_ready;

  // State register and datapath registers.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values; the combinational blocks use blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grp_idx  <= '0;
      step_cnt <= '0;
      pm_sel   <= 1'b0;
      rx_pair  <= 2'b00;
      tb_first <= 1'b0;
    end else begin
      state    <= state_nxt;
      grp_idx  <= grp_idx_nxt;
      step_cnt <= step_cnt_nxt;
      pm_sel   <= pm_sel_nxt;
      rx_pair  <= rx_pair_nxt;
      tb_first <= tb_first_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    grp_idx_nxt  = grp_idx;
    step_cnt_nxt = step_cnt;
    pm_sel_nxt   = pm_sel;
    rx_pair_nxt  = accept ? rx_pair_in : rx_pair;
    tb_first_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = RUN;
          grp_idx_nxt = '0;
        end
      end

      RUN: begin
        if (last_grp) begin
          pm_sel_nxt  = ~pm_sel;
          grp_idx_nxt = '0;
          if (last_step) begin
            step_cnt_nxt = '0;
            state_nxt    = TB_WAIT;
            tb_first_nxt = 1'b1;
          end else begin
            step_cnt_nxt = step_cnt + 1'b1;
            // A pair accepted on the final group starts the next step with
            // no idle bubble.
            state_nxt    = accept ? RUN : IDLE;
          end
        end else begin
          grp_idx_nxt = grp_idx + 1'b1;
        end
      end

      TB_WAIT: begin
        if (tb_done) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    acs_en    = (state == RUN);
    step_done = (state == RUN) && last_grp;
    busy      = (state != IDLE);
    tb_start  = (state == TB_WAIT) && tb_first;
    // The final step of a traceback window refuses new input so the
    // traceback sees a stable window.
    in_ready  = !rst &&
                ((state == IDLE) ||
                 ((state == RUN) && last_grp && !last_step));
  end

endmodule

// File: tb/tb_bmc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bmc_seq_ctrl
//
// Directed bench for bmc_seq_ctrl with NUM_GROUPS=8, TB_LEN=4. Inputs change
// 1 time unit after the rising edge; outputs are compared 2 units after it.
// -----------------------------------------------------------------------------
module tb_bmc_seq_ctrl;

  localparam int NG = 8;
  localparam int TL = 4;
  localparam int GW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [1:0]    rx_pair_in;
  logic          in_ready;
  logic [1:0]    rx_pair;
  logic [GW-1:0] grp_idx;
  logic          acs_en;
  logic          step_done;
  logic          pm_sel;
  logic          tb_start;
  logic          tb_done;
  logic          busy;

  int tests_run = 0;
  int tests_failed = 0;

  bmc_seq_ctrl #(.NUM_GROUPS(NG), .TB_LEN(TL), .GW(GW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .rx_pair_in (rx_pair_in),
    .in_ready   (in_ready),
    .rx_pair    (rx_pair),
    .grp_idx    (grp_idx),
    .acs_en     (acs_en),
    .step_done  (step_done),
    .pm_sel     (pm_sel),
    .tb_start   (tb_start),
    .tb_done    (tb_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns 1 unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    rx_pair_in = 2'b00;
    tb_done = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  logic [1:0] pairs [4];
  int pulses;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    rx_pair_in = 2'b00;
    tb_done = 1'b0;

    // ---------------- reset state ----------------
    cyc();
    settle();
    check("rst_in_ready", in_ready, 0);
    check("rst_acs_en", acs_en, 0);
    check("rst_busy", busy, 0);
    check("rst_tb_start", tb_start, 0);
    rst = 1'b0;
    cyc();
    settle();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_grp", grp_idx, 0);
    check("post_rst_pm_sel", pm_sel, 0);
    check("post_rst_rx_pair", rx_pair, 2'b00);
    check("post_rst_step_done", step_done, 0);

    // ---------------- single pair ----------------
    in_valid = 1'b1;
    rx_pair_in = 2'b10;
    settle();
    check("single_in_ready_idle", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    rx_pair_in = 2'b00;
    for (int g = 0; g < NG; g++) begin
      settle();
      check("single_acs_en", acs_en, 1);
      check("single_grp", grp_idx, g);
      check("single_rx_pair", rx_pair, 2'b10);
      check("single_step_done", step_done, (g == NG - 1));
      check("single_in_ready", in_ready, (g == NG - 1));
      check("single_pm_sel", pm_sel, 0);
      check("single_busy", busy, 1);
      cyc();
    end
    settle();
    check("single_end_busy", busy, 0);
    check("single_end_acs_en", acs_en, 0);
    check("single_end_pm_sel", pm_sel, 1);
    check("single_end_grp", grp_idx, 0);

    // ---------------- streaming ----------------
    do_reset();
    pairs[0] = 2'b01;
    pairs[1] = 2'b10;
    pairs[2] = 2'b11;
    pulses = 0;
    in_valid = 1'b1;
    rx_pair_in = pairs[0];
    cyc();
    for (int p = 0; p < 3; p++) begin
      for (int g = 0; g < NG; g++) begin
        in_valid = (p < 2);
        rx_pair_in = (p < 2) ? pairs[p + 1] : 2'b00;
        settle();
        check("stream_grp", grp_idx, g);
        check("stream_acs_en", acs_en, 1);
        check("stream_rx_pair", rx_pair, pairs[p]);
        check("stream_step_done", step_done, (g == NG - 1));
        if (step_done) pulses++;
        cyc();
      end
    end
    in_valid = 1'b0;
    settle();
    check("stream_pulses", pulses, 3);
    check("stream_end_busy", busy, 0);
    check("stream_end_pm_sel", pm_sel, 1);

    // ---------------- traceback and backpressure ----------------
    do_reset();
    pairs[0] = 2'b00;
    pairs[1] = 2'b01;
    pairs[2] = 2'b10;
    pairs[3] = 2'b01;
    in_valid = 1'b1;
    rx_pair_in = pairs[0];
    cyc();
    for (int p = 0; p < 4; p++) begin
      for (int g = 0; g < NG; g++) begin
        // During the final step a pending 11 is offered and must be held off.
        in_valid = 1'b1;
        rx_pair_in = (p < 3) ? pairs[p + 1] : 2'b11;
        settle();
        check("tb_run_grp", grp_idx, g);
        check("tb_run_rx_pair", rx_pair, pairs[p]);
        check("tb_run_in_ready", in_ready, (g == NG - 1) && (p < 3));
        check("tb_run_tb_start", tb_start, 0);
        cyc();
      end
    end
    for (int i = 0; i < 10; i++) begin
      settle();
      check("tbw_tb_start", tb_start, (i == 0));
      check("tbw_in_ready", in_ready, 0);
      check("tbw_acs_en", acs_en, 0);
      check("tbw_busy", busy, 1);
      check("tbw_rx_pair", rx_pair, 2'b01);
      cyc();
    end
    check("tbw_pm_sel", pm_sel, 0);
    tb_done = 1'b1;
    settle();
    check("tbw_done_in_ready", in_ready, 0);
    cyc();
    tb_done = 1'b0;
    settle();
    check("after_tb_busy", busy, 0);
    check("after_tb_in_ready", in_ready, 1);
    check("after_tb_rx_pair_hold", rx_pair, 2'b01);
    cyc();
    settle();
    check("bp_accept_rx_pair", rx_pair, 2'b11);
    check("bp_accept_acs_en", acs_en, 1);
    check("bp_accept_grp", grp_idx, 0);
    // step_cnt restarted: the next launch comes after exactly 4 more steps.
    for (int k = 0; k < TL * NG; k++) begin
      settle();
      check("restart_acs_en", acs_en, 1);
      check("restart_tb_start", tb_start, 0);
      cyc();
    end
    in_valid = 1'b0;
    tb_done = 1'b1;
    settle();
    check("restart_tb_start_pulse", tb_start, 1);
    cyc();
    tb_done = 1'b0;
    settle();
    check("tb_done_on_start_busy", busy, 0);
    check("tb_done_on_start_tb_start", tb_start, 0);

    // ---------------- reset mid-step ----------------
    do_reset();
    in_valid = 1'b1;
    rx_pair_in = 2'b11;
    cyc();
    in_valid = 1'b0;
    for (int g = 0; g < 5; g++) cyc();
    settle();
    check("mid_grp5", grp_idx, 5);
    rst = 1'b1;
    settle();
    check("mid_rst_in_ready", in_ready, 0);
    cyc();
    rst = 1'b0;
    settle();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grp", grp_idx, 0);
    check("mid_rst_pm_sel", pm_sel, 0);
    check("mid_rst_acs_en", acs_en, 0);
    check("mid_rst_step_done", step_done, 0);
    check("mid_rst_rx_pair", rx_pair, 2'b00);

    // ---------------- reset in TB_WAIT ----------------
    in_valid = 1'b1;
    rx_pair_in = 2'b10;
    cyc();
    for (int k = 0; k < TL * NG; k++) cyc();
    in_valid = 1'b0;
    settle();
    check("rtb_tb_start", tb_start, 1);
    cyc();
    settle();
    check("rtb_second_tb_start", tb_start, 0);
    check("rtb_busy", busy, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    settle();
    check("rtb_rst_busy", busy, 0);
    check("rtb_rst_tb_start", tb_start, 0);
    check("rtb_rst_in_ready", in_ready, 1);
    check("rtb_rst_pm_sel", pm_sel, 0);

    // ---------------- stray tb_done ----------------
    tb_done = 1'b1;
    cyc();
    settle();
    check("stray_idle_busy", busy, 0);
    in_valid = 1'b1;
    rx_pair_in = 2'b01;
    cyc();
    for (int k = 0; k < TL * NG; k++) begin
      settle();
      check("stray_run_acs_en", acs_en, 1);
      check("stray_run_grp", grp_idx, k % NG);
      check("stray_run_tb_start", tb_start, 0);
      cyc();
    end
    in_valid = 1'b0;
    settle();
    check("stray_tb_start", tb_start, 1);
    cyc();
    tb_done = 1'b0;
    settle();
    check("stray_end_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
